// File: rtl/o_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : o_writeback_if
// Description : Bus bundle for the output write-back stage. It carries the
//               row handshake from the PE (vld_in / rdy_out / o_vec_in) and
//               the word-wide SRAM write port (sram_we / sram_addr /
//               sram_wdata / sram_wr_rdy).
//               master : the surrounding system (PE producer + O SRAM)
//               slave  : the write-back stage itself
// Revision    : 1.0  initial release
// ============================================================================
interface o_writeback_if #(
    parameter int EMB_DIM        = 64,
    parameter int ELEM_W         = 16,
    parameter int ELEMS_PER_WORD = 8,
    parameter int ADDR_W         = 10
);
    logic                             vld_in;
    logic                             rdy_out;
    logic [EMB_DIM*ELEM_W-1:0]        o_vec_in;
    logic                             sram_we;
    logic [ADDR_W-1:0]                sram_addr;
    logic [ELEMS_PER_WORD*ELEM_W-1:0] sram_wdata;
    logic                             sram_wr_rdy;

    modport master (
        output vld_in, o_vec_in, sram_wr_rdy,
        input  rdy_out, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        input  vld_in, o_vec_in, sram_wr_rdy,
        output rdy_out, sram_we, sram_addr, sram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/o_writeback.sv
`default_nettype none
// ============================================================================
// Module      : o_writeback
// Description : Output write-back stage. Captures one normalised output row
//               per handshake, then serialises it into WPR word writes to the
//               O SRAM at base_addr + row*WPR + beat (modulo 2^ADDR_W).
//               Pulses done for one cycle after the last write of a tile.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               start           - begin tile (honoured in IDLE only)
//               base_addr       - word address of row 0 / word 0
//               num_rows        - rows in the tile (0 behaves as 1)
//               bus (slave)     - row handshake in, SRAM write port out
//               busy            - high in every state except IDLE
//               done            - one-cycle completion pulse
//               rows_written    - fully written rows in the current tile
// Revision    : 1.0  initial release
// ============================================================================
module o_writeback #(
    parameter int EMB_DIM        = 64,
    parameter int ELEM_W         = 16,
    parameter int ELEMS_PER_WORD = 8,
    parameter int ADDR_W         = 10,
    parameter int ROW_W          = 8
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 start,
    input  wire  [ADDR_W-1:0]   base_addr,
    input  wire  [ROW_W-1:0]    num_rows,
    o_writeback_if.slave        bus,
    output logic                busy,
    output logic                done,
    output logic [ROW_W-1:0]    rows_written
);

    localparam int WPR    = EMB_DIM / ELEMS_PER_WORD;
    localparam int WORD_W = ELEMS_PER_WORD * ELEM_W;
    localparam int BEAT_W = (WPR > 1) ? $clog2(WPR) : 1;

    localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(WPR - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [EMB_DIM*ELEM_W-1:0] r_row_buf;
    logic [BEAT_W-1:0]         r_beat;
    logic [ADDR_W-1:0]         r_addr;
    logic [ROW_W-1:0]          r_num_rows;
    logic [ROW_W-1:0]          r_rows_written;

    logic w_capture;
    logic w_beat_done;
    logic w_last_beat;
    logic w_last_row;

    assign w_capture   = (r_state == S_ACCEPT) && bus.vld_in;
    assign w_beat_done = (r_state == S_WRITE) && bus.sram_wr_rdy;
    assign w_last_beat = (r_beat == c_last_beat);
    // The row index of the row being written equals the number of rows
    // already completed, so the completed-row counter doubles as row index.
    assign w_last_row  = (r_rows_written == r_num_rows - ROW_W'(1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        bus.rdy_out = 1'b0;
        bus.sram_we = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                bus.rdy_out = 1'b1;
                if (bus.vld_in) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                bus.sram_we = 1'b1;
                if (bus.sram_wr_rdy && w_last_beat) begin
                    w_state_nxt = w_last_row ? S_DONE : S_ACCEPT;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: row buffer, beat/address/row counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_buf      <= '0;
            r_beat         <= '0;
            r_addr         <= '0;
            r_num_rows     <= '0;
            r_rows_written <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_addr         <= base_addr;
                r_num_rows     <= (num_rows == '0) ? ROW_W'(1) : num_rows;
                r_rows_written <= '0;
                r_beat         <= '0;
            end
            if (w_capture) begin
                r_row_buf <= bus.o_vec_in;
                r_beat    <= '0;
            end
            // Rows are laid out contiguously, so the address simply steps by
            // one word per completed beat and wraps at 2^ADDR_W. The buffer
            // shifts down so the current beat always sits in the low word.
            if (w_beat_done) begin
                r_row_buf <= r_row_buf >> WORD_W;
                r_addr    <= r_addr + ADDR_W'(1);
                if (w_last_beat) begin
                    r_beat         <= '0;
                    r_rows_written <= r_rows_written + ROW_W'(1);
                end else begin
                    r_beat <= r_beat + BEAT_W'(1);
                end
            end
        end
    end

    assign bus.sram_addr  = r_addr;
    assign bus.sram_wdata = r_row_buf[WORD_W-1:0];
    assign rows_written   = r_rows_written;

endmodule
`default_nettype wire

// File: tb/tb_o_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_o_writeback
// Description : Self-checking bench for o_writeback. Expected SRAM writes are
//               queued when a row is handed over and retired as the DUT
//               completes each beat.
// Revision    : 1.0  initial release
// ============================================================================
module tb_o_writeback;

    localparam int EMB_DIM = 64;
    localparam int ELEM_W  = 16;
    localparam int EPW     = 8;
    localparam int ADDR_W  = 10;
    localparam int ROW_W   = 8;
    localparam int WPR     = EMB_DIM / EPW;
    localparam int WORD_W  = EPW * ELEM_W;
    localparam int VEC_W   = EMB_DIM * ELEM_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ROW_W-1:0]  num_rows = '0;
    logic              busy;
    logic              done;
    logic [ROW_W-1:0]  rows_written;

    o_writeback_if #(
        .EMB_DIM(EMB_DIM), .ELEM_W(ELEM_W), .ELEMS_PER_WORD(EPW), .ADDR_W(ADDR_W)
    ) bus ();

    o_writeback #(
        .EMB_DIM(EMB_DIM), .ELEM_W(ELEM_W), .ELEMS_PER_WORD(EPW),
        .ADDR_W(ADDR_W), .ROW_W(ROW_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_rows     (num_rows),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .rows_written (rows_written)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_t;

    wr_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_wr_cycle = 0;
    int n_writes = 0;
    int cap_cycle = 0;
    int tile_base = 0;
    int tile_row  = 0;
    logic              stall_prev = 1'b0;
    logic [ADDR_W-1:0] stall_addr = '0;
    logic [WORD_W-1:0] stall_data = '0;

    task automatic check(input string tag, input logic [WORD_W-1:0] obs,
                         input logic [WORD_W-1:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock step. Inputs are final when this is called, so a beat that
    // is presented with sram_wr_rdy high now completes at the coming edge.
    task automatic tick();
        wr_t e;
        if (!rst && bus.sram_we && bus.sram_wr_rdy) begin
            check("sb_has_entry", WORD_W'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("wr_addr", bus.sram_addr, e.addr);
                check("wr_data", bus.sram_wdata, e.data);
            end
            last_wr_cycle = cyc;
            n_writes++;
        end
        stall_prev = !rst && bus.sram_we && !bus.sram_wr_rdy;
        stall_addr = bus.sram_addr;
        stall_data = bus.sram_wdata;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (stall_prev && bus.sram_we) begin
                check("stall_addr_stable", bus.sram_addr, stall_addr);
                check("stall_data_stable", bus.sram_wdata, stall_data);
            end
            if (bus.sram_we) begin
                check("rdy_low_in_write", bus.rdy_out, 0);
            end
        end
    endtask

    function automatic logic [VEC_W-1:0] make_vec(input int seed);
        logic [VEC_W-1:0] v;
        for (int i = 0; i < EMB_DIM; i++) begin
            v[i*ELEM_W +: ELEM_W] = ELEM_W'(seed * EMB_DIM + i);
        end
        return v;
    endfunction

    task automatic start_tile(input int base, input int nrows);
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        num_rows  = ROW_W'(nrows);
        tile_base = base;
        tile_row  = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic send_row(input int seed, input bit hold);
        logic [VEC_W-1:0] v;
        wr_t e;
        int n;
        v = make_vec(seed);
        bus.vld_in   = 1'b1;
        bus.o_vec_in = v;
        n = 0;
        while (!bus.rdy_out && n < 200) begin
            tick();
            n++;
        end
        if (!bus.rdy_out) begin
            check("rdy_timeout", bus.rdy_out, 1);
            bus.vld_in = 1'b0;
            return;
        end
        cap_cycle = cyc;
        for (int b = 0; b < WPR; b++) begin
            e.addr = ADDR_W'(tile_base + tile_row * WPR + b);
            e.data = v[b*WORD_W +: WORD_W];
            sb.push_back(e);
        end
        tile_row++;
        tick();
        if (!hold) begin
            bus.vld_in = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        if (!done) begin
            check("done_timeout", done, 1);
        end else begin
            check("done_after_last_wr", WORD_W'(cyc - last_wr_cycle), 1);
        end
    endtask

    initial begin
        int w0;
        int cap_first;
        bus.vld_in      = 1'b0;
        bus.o_vec_in    = '0;
        bus.sram_wr_rdy = 1'b1;

        // ---------------- reset state
        repeat (3) tick();
        check("rst_rdy_out", bus.rdy_out, 0);
        check("rst_sram_we", bus.sram_we, 0);
        check("rst_sram_addr", bus.sram_addr, 0);
        check("rst_sram_wdata", bus.sram_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rows_written", rows_written, 0);
        rst = 1'b0;
        tick();

        // ---------------- test 1: single row, base 0x010
        w0 = n_writes;
        check("t1_idle_rdy", bus.rdy_out, 0);
        start_tile(12'h010, 1);
        check("t1_rdy_after_start", bus.rdy_out, 1);
        check("t1_busy", busy, 1);
        send_row(0, 1'b0);
        check("t1_beat0_addr", bus.sram_addr, 10'h010);
        check("t1_beat0_data", bus.sram_wdata,
              128'h0007_0006_0005_0004_0003_0002_0001_0000);
        wait_done();
        check("t1_rows_written", rows_written, 1);
        check("t1_nwrites", WORD_W'(n_writes - w0), WPR);
        tick();
        check("t1_done_one_cycle", done, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_rows_hold", rows_written, 1);

        // ---------------- test 2: three rows back to back, vld held high
        w0 = n_writes;
        start_tile(0, 3);
        check("t2_rows_cleared", rows_written, 0);
        send_row(1, 1'b1);
        cap_first = cap_cycle;
        send_row(2, 1'b1);
        check("t2_row_period", WORD_W'(cap_cycle - cap_first), 1 + WPR);
        send_row(3, 1'b0);
        wait_done();
        check("t2_first_cap_to_last_wr", WORD_W'(last_wr_cycle - cap_first + 1), 27);
        check("t2_rows_written", rows_written, 3);
        check("t2_nwrites", WORD_W'(n_writes - w0), 3 * WPR);
        tick();

        // ---------------- test 3: 5-cycle stall on beat 3
        w0 = n_writes;
        start_tile(12'h100, 1);
        send_row(4, 1'b0);
        repeat (3) tick();
        check("t3_beat3_addr", bus.sram_addr, 10'h103);
        bus.sram_wr_rdy = 1'b0;
        repeat (5) tick();
        check("t3_we_during_stall", bus.sram_we, 1);
        check("t3_addr_after_stall", bus.sram_addr, 10'h103);
        bus.sram_wr_rdy = 1'b1;
        wait_done();
        check("t3_nwrites", WORD_W'(n_writes - w0), WPR);
        tick();

        // ---------------- test 4: address wrap-around
        start_tile(12'h3FC, 1);
        send_row(5, 1'b0);
        check("t4_first_addr", bus.sram_addr, 10'h3FC);
        wait_done();
        check("t4_rows_written", rows_written, 1);
        tick();

        // ---------------- num_rows = 0 behaves as one row
        start_tile(12'h200, 0);
        send_row(6, 1'b0);
        wait_done();
        check("t4b_rows_zero_as_one", rows_written, 1);
        tick();

        // ---------------- test 5: reset at beat 4 of row 1
        start_tile(12'h040, 3);
        send_row(7, 1'b0);
        send_row(8, 1'b0);
        repeat (4) tick();
        check("t5_beat4_addr", bus.sram_addr, 10'h04C);
        check("t5_rows_before_rst", rows_written, 1);
        rst = 1'b1;
        tick();
        check("t5_we_after_rst", bus.sram_we, 0);
        check("t5_busy_after_rst", busy, 0);
        check("t5_rows_after_rst", rows_written, 0);
        check("t5_rdy_after_rst", bus.rdy_out, 0);
        check("t5_pending_beats", WORD_W'(sb.size()), 4);
        sb.delete();
        rst = 1'b0;
        repeat (2) tick();
        check("t5_idle_we", bus.sram_we, 0);
        w0 = n_writes;
        start_tile(12'h080, 2);
        send_row(9, 1'b0);
        send_row(10, 1'b0);
        wait_done();
        check("t5_clean_rows", rows_written, 2);
        check("t5_clean_nwrites", WORD_W'(n_writes - w0), 2 * WPR);
        tick();

        // ---------------- test 6: vld in IDLE, start+vld together, start mid-tile
        bus.vld_in   = 1'b1;
        bus.o_vec_in = make_vec(99);
        tick();
        check("t6_idle_vld_rdy", bus.rdy_out, 0);
        tick();
        check("t6_idle_vld_busy", busy, 0);
        bus.vld_in = 1'b0;
        tick();
        w0 = n_writes;
        start     = 1'b1;
        base_addr = 10'h120;
        num_rows  = 8'd2;
        tile_base = 12'h120;
        tile_row  = 0;
        bus.vld_in   = 1'b1;
        bus.o_vec_in = make_vec(98);
        tick();
        start      = 1'b0;
        bus.vld_in = 1'b0;
        tick();
        check("t6_no_capture_with_start", bus.rdy_out, 1);
        check("t6_no_write_with_start", bus.sram_we, 0);
        send_row(11, 1'b0);
        repeat (2) tick();
        start     = 1'b1;
        base_addr = 10'h2AA;
        num_rows  = 8'd5;
        tick();
        start = 1'b0;
        send_row(12, 1'b0);
        wait_done();
        check("t6_rows_written", rows_written, 2);
        check("t6_nwrites", WORD_W'(n_writes - w0), 2 * WPR);
        tick();
        check("t6_idle_after_done", busy, 0);

        check("sb_empty_at_end", WORD_W'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
